// File: rtl/ans_decoder_pkg.sv
// Shared rANS definitions: default widths, decoder FSM encoding and the
// initial-state rule that ties the encoder and decoder together.
package ans_decoder_pkg;

   localparam int ANS_SYM_WIDTH   = 8;
   localparam int ANS_CNT_WIDTH   = 8;
   localparam int ANS_STATE_WIDTH = 16;
   localparam int ANS_NSYM_WIDTH  = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DECODE = 3'd1,
      ST_EMIT   = 3'd2,
      ST_RENORM = 3'd3,
      ST_DONE   = 3'd4
   } ans_state_e;

   // The encoder starts from x = M+1, so a clean decode must end there.
   function automatic logic [63:0] ans_init_state(input logic [63:0] total_count);
      return total_count + 64'd1;
   endfunction

endpackage

// File: rtl/ans_div_mod.sv
// Combinational x / M and x % M; a zero divisor yields zeros rather than X.
module ans_div_mod
   import ans_decoder_pkg::*;
#(
   parameter int STATE_WIDTH = ANS_STATE_WIDTH
) (
   input  logic [STATE_WIDTH-1:0] dividend_i,
   input  logic [STATE_WIDTH-1:0] divisor_i,
   output logic [STATE_WIDTH-1:0] quot_o,
   output logic [STATE_WIDTH-1:0] rem_o
);

   always_comb begin
      quot_o = '0;
      rem_o  = '0;
      if (divisor_i != '0) begin
         quot_o = dividend_i / divisor_i;
         rem_o  = dividend_i % divisor_i;
      end
   end

endmodule

// File: rtl/ans_decoder.sv
// rANS stream decoder: recovers symbols in reverse encode order, pulling
// renormalisation words LIFO and emitting symbols over valid/ready.
module ans_decoder
   import ans_decoder_pkg::*;
#(
   parameter int SYM_WIDTH   = ANS_SYM_WIDTH,
   parameter int CNT_WIDTH   = ANS_CNT_WIDTH,
   parameter int STATE_WIDTH = ANS_STATE_WIDTH,
   parameter int NSYM_WIDTH  = ANS_NSYM_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           ena,
   input  logic [STATE_WIDTH-1:0]         total_count,
   input  logic [STATE_WIDTH-1:0]         init_state,
   input  logic [NSYM_WIDTH-1:0]          init_nsym,
   input  logic                           init_vld,
   output logic [STATE_WIDTH-1:0]         lut_slot,
   input  logic [SYM_WIDTH-1:0]           lut_sym,
   input  logic [CNT_WIDTH-1:0]           lut_count,
   input  logic [SYM_WIDTH+CNT_WIDTH-1:0] lut_cum,
   input  logic [SYM_WIDTH-1:0]           in_data,
   input  logic                           in_vld,
   output logic                           in_rdy,
   output logic [SYM_WIDTH-1:0]           out_sym,
   output logic                           out_vld,
   input  logic                           out_rdy,
   output logic                           done,
   output logic                           err
);

   localparam int PW = 2 * STATE_WIDTH;

   ans_state_e                state_q, state_d;
   logic [STATE_WIDTH-1:0]    x_q, x_d;
   logic [NSYM_WIDTH-1:0]     rem_q, rem_d;
   logic [SYM_WIDTH-1:0]      sym_q, sym_d;
   logic                      vld_q, vld_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;

   logic [STATE_WIDTH-1:0]    quot, slot;
   logic [PW-1:0]             dec_full;
   logic [STATE_WIDTH-1:0]    x_dec, x_shift, x_final;
   logic                      x_below_m;

   ans_div_mod #(.STATE_WIDTH(STATE_WIDTH)) u_div (
      .dividend_i (x_q),
      .divisor_i  (total_count),
      .quot_o     (quot),
      .rem_o      (slot)
   );

   // Decode step is done at double width so count*q cannot overflow before the subtract.
   assign dec_full  = PW'(lut_count) * PW'(quot) + PW'(slot) - PW'(lut_cum);
   assign x_dec     = dec_full[STATE_WIDTH-1:0];
   assign x_shift   = (x_q << SYM_WIDTH) | STATE_WIDTH'(in_data);
   assign x_final   = STATE_WIDTH'(ans_init_state(64'(total_count)));
   assign x_below_m = (x_q < total_count);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         rem_q   <= '0;
         sym_q   <= '0;
         vld_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else if (ena) begin
         state_q <= state_d;
         x_q     <= x_d;
         rem_q   <= rem_d;
         sym_q   <= sym_d;
         vld_q   <= vld_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      rem_d   = rem_q;
      sym_d   = sym_q;
      vld_d   = vld_q;
      done_d  = done_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (init_vld) begin
               x_d    = init_state;
               rem_d  = init_nsym;
               done_d = 1'b0;
               err_d  = 1'b0;
               if (total_count == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else if (init_nsym == '0) begin
                  state_d = ST_RENORM;
               end else begin
                  state_d = ST_DECODE;
               end
            end
         end
         ST_DECODE: begin
            x_d     = x_dec;
            sym_d   = lut_sym;
            vld_d   = 1'b1;
            state_d = ST_EMIT;
         end
         ST_EMIT: begin
            if (out_rdy) begin
               vld_d   = 1'b0;
               rem_d   = rem_q - NSYM_WIDTH'(1);
               state_d = ST_RENORM;
            end
         end
         ST_RENORM: begin
            if (x_below_m) begin
               if (in_vld) x_d = x_shift;
            end else if (rem_q != '0) begin
               state_d = ST_DECODE;
            end else begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               err_d   = (x_q != x_final);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_rdy   = (state_q == ST_RENORM) && x_below_m;
      lut_slot = slot;
      out_sym  = sym_q;
      out_vld  = vld_q;
      done     = done_q;
      err      = err_q;
   end

endmodule

// File: tb/tb_ans_decoder.sv
// Scoreboard bench for ans_decoder with M=4 and table A(3,0), B(1,3).
module tb_ans_decoder;
   import ans_decoder_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b1;
   logic [15:0] total_count = 16'd4;
   logic [15:0] init_state = '0;
   logic [15:0] init_nsym = '0;
   logic        init_vld = 1'b0;
   logic [15:0] lut_slot;
   logic [7:0]  lut_sym;
   logic [7:0]  lut_count;
   logic [15:0] lut_cum;
   logic [7:0]  in_data = '0;
   logic        in_vld = 1'b0;
   logic        in_rdy;
   logic [7:0]  out_sym;
   logic        out_vld;
   logic        out_rdy = 1'b1;
   logic        done;
   logic        err;

   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [7:0]  sb[$];
   logic [7:0]  mon_exp;
   logic        seen_rdy = 1'b0;

   localparam logic [7:0] SYM_A = 8'h41;
   localparam logic [7:0] SYM_B = 8'h42;

   always #5 clk = ~clk;

   ans_decoder dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .total_count(total_count),
      .init_state(init_state), .init_nsym(init_nsym), .init_vld(init_vld),
      .lut_slot(lut_slot), .lut_sym(lut_sym), .lut_count(lut_count), .lut_cum(lut_cum),
      .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
      .out_sym(out_sym), .out_vld(out_vld), .out_rdy(out_rdy),
      .done(done), .err(err)
   );

   always_comb begin
      if (lut_slot < 16'd3) begin
         lut_sym = SYM_A; lut_count = 8'd3; lut_cum = 16'd0;
      end else begin
         lut_sym = SYM_B; lut_count = 8'd1; lut_cum = 16'd3;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   // Monitor: a handshake seen on the falling edge is consumed on the next rising edge.
   always @(negedge clk) begin
      if (rst_n && ena && out_vld && out_rdy) begin
         if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL out_sym_unexpected: got %0h required none", out_sym);
         end else begin
            mon_exp = sb.pop_front();
            chk("out_sym", 32'(out_sym), 32'(mon_exp));
         end
      end
      if (in_rdy) seen_rdy = 1'b1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic init(input logic [15:0] x, input logic [15:0] n);
      init_state = x;
      init_nsym  = n;
      init_vld   = 1'b1;
      tick(1);
      init_vld   = 1'b0;
   endtask

   // sel: 0 = done, 1 = in_rdy, 2 = out_vld
   task automatic wait_cond(input int sel, input string name);
      logic c;
      for (int i = 0; i < 100; i++) begin
         c = (sel == 0) ? done : (sel == 1) ? in_rdy : out_vld;
         if (c) return;
         tick(1);
      end
      chk(name, 32'd0, 32'd1);
   endtask

   task automatic feed(input logic [7:0] w);
      in_data = w;
      in_vld  = 1'b1;
      tick(1);
      in_vld  = 1'b0;
   endtask

   initial begin
      tick(2);
      chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      chk("rst_x", 32'(dut.x_q), 32'd0);
      chk("rst_out_vld", 32'(out_vld), 32'd0);
      chk("rst_out_sym", 32'(out_sym), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      tick(1);

      // Two symbols, no renormalisation
      out_rdy = 1'b1; seen_rdy = 1'b0;
      sb.push_back(SYM_B); sb.push_back(SYM_A);
      init(16'd27, 16'd2);
      wait_cond(0, "t1_done_timeout");
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_err", 32'(err), 32'd0);
      chk("t1_x", 32'(dut.x_q), 32'd5);
      chk("t1_no_in_rdy", 32'(seen_rdy), 32'd0);

      // Renormalisation with one word
      sb.push_back(SYM_B);
      init(16'd7, 16'd1);
      wait_cond(1, "t2_rdy_timeout");
      chk("t2_x_before", 32'(dut.x_q), 32'd1);
      feed(8'h05);
      chk("t2_x_after", 32'(dut.x_q), 32'd261);
      wait_cond(0, "t2_done_timeout");
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_err", 32'(err), 32'd1);

      // Output backpressure
      out_rdy = 1'b0;
      sb.push_back(SYM_B); sb.push_back(SYM_A);
      init(16'd27, 16'd2);
      wait_cond(2, "t3_vld_timeout");
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("t3_hold_vld", 32'(out_vld), 32'd1);
         chk("t3_hold_sym", 32'(out_sym), 32'(SYM_B));
         chk("t3_hold_state", 32'(dut.state_q), 32'(ST_EMIT));
      end
      out_rdy = 1'b1;
      wait_cond(0, "t3_done_timeout");
      chk("t3_err", 32'(err), 32'd0);
      chk("t3_x", 32'(dut.x_q), 32'd5);

      // Input stall
      sb.push_back(SYM_B);
      init(16'd7, 16'd1);
      wait_cond(1, "t4_rdy_timeout");
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk("t4_in_rdy", 32'(in_rdy), 32'd1);
         chk("t4_x_held", 32'(dut.x_q), 32'd1);
         chk("t4_not_done", 32'(done), 32'd0);
      end
      feed(8'h05);
      wait_cond(0, "t4_done_timeout");
      chk("t4_err", 32'(err), 32'd1);

      // Asynchronous reset while in EMIT
      out_rdy = 1'b0;
      sb.push_back(SYM_B); sb.push_back(SYM_A);
      init(16'd27, 16'd2);
      wait_cond(2, "t5_vld_timeout");
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_out_vld", 32'(out_vld), 32'd0);
      chk("t5_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      sb.delete();
      tick(1);
      rst_n = 1'b1;
      out_rdy = 1'b1;
      tick(1);
      sb.push_back(SYM_B); sb.push_back(SYM_A);
      init(16'd27, 16'd2);
      wait_cond(0, "t5_done_timeout");
      chk("t5_err", 32'(err), 32'd0);
      chk("t5_x", 32'(dut.x_q), 32'd5);

      // Clock enable low during DECODE
      sb.push_back(SYM_B); sb.push_back(SYM_A);
      init(16'd27, 16'd2);
      ena = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("t6_ena_state", 32'(dut.state_q), 32'(ST_DECODE));
         chk("t6_ena_x", 32'(dut.x_q), 32'd27);
         chk("t6_ena_vld", 32'(out_vld), 32'd0);
      end
      ena = 1'b1;
      wait_cond(0, "t6_done_timeout");
      chk("t6_err", 32'(err), 32'd0);
      chk("t6_x", 32'(dut.x_q), 32'd5);

      // M == 0 at init
      total_count = 16'd0;
      init(16'd27, 16'd2);
      chk("t6_m0_done", 32'(done), 32'd1);
      chk("t6_m0_err", 32'(err), 32'd1);
      total_count = 16'd4;

      // Zero symbols: state already equals M+1
      init(16'd5, 16'd0);
      chk("t7_clear_done", 32'(done), 32'd0);
      wait_cond(0, "t7_done_timeout");
      chk("t7_err", 32'(err), 32'd0);

      tick(2);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
